// File: rtl/my_de0_nano.sv
// my_de0_nano: DE0-Nano board top holding a minimal 16-bit single-cycle
// load/store processor with a built-in program ROM and a data RAM.
// The data-memory bus is exported on the GPIO headers so every store can
// be watched from outside.
//
// Ports:
//   CLOCK_50   in   1   system clock, all state updates on the rising edge
//   GPIO_0_PI  in  34   bit 1 = synchronous active-high reset, rest unused
//   GPIO_1     out 34   [15:0] WriteData, [31:16] ReadData, [32] 0,
//                       [33] MemWrite
//   GPIO_2     out 13   DataAdr (data-memory word address)
//
// Parameters:
//   RAM_AW    data-RAM address bits; DataAdr[12:RAM_AW] alias
//   ROM_AW    program-ROM address bits (PC width); unused words are NOP
//   TEST_ROM  1 selects an alternative instruction-set exercise program
module my_de0_nano #(
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned ROM_AW   = 6,
  parameter bit          TEST_ROM = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic [33:0] GPIO_0_PI,
  output logic [33:0] GPIO_1,
  output logic [12:0] GPIO_2
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_MOVI = 4'd5,
    OP_LDR  = 4'd6,
    OP_STR  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_B    = 4'd9,
    OP_NOP  = 4'd15
  } op_e;

  // Instruction encoders used to spell out the ROM contents
  function automatic logic [15:0] enc_r(op_e op, logic [2:0] rd, logic [2:0] rs,
                                        logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(op_e op, logic [2:0] rd, logic [2:0] rs,
                                        logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [15:0] enc_m(logic [2:0] rd, logic [8:0] imm);
    return {OP_MOVI, rd, imm};
  endfunction

  function automatic logic [15:0] enc_b(logic [11:0] off);
    return {OP_B, off};
  endfunction

  // 5 x 4 by repeated addition, store to 220, read it back, then idle
  function automatic logic [15:0] main_rom(int unsigned a);
    case (a)
      0:       return enc_m(3'd1, 9'd0);
      1:       return enc_m(3'd2, 9'd5);
      2:       return enc_i(OP_ADDI, 3'd1, 3'd1, 6'd4);
      3:       return enc_i(OP_ADDI, 3'd2, 3'd2, 6'h3F);
      4:       return enc_i(OP_BEQ, 3'd2, 3'd0, 6'd1);
      5:       return enc_b(12'hFFC);
      6:       return enc_m(3'd3, 9'd220);
      7:       return enc_i(OP_STR, 3'd1, 3'd3, 6'd0);
      8:       return enc_i(OP_LDR, 3'd5, 3'd3, 6'd0);
      9:       return enc_b(12'hFFF);
      default: return {OP_NOP, 12'h000};
    endcase
  endfunction

  // Exercises SUB wrap, ADDI overflow, R0 discard, BEQ both ways, aliasing
  function automatic logic [15:0] test_rom(int unsigned a);
    case (a)
      0:                      return enc_m(3'd1, 9'd1);
      1:                      return enc_r(OP_SUB, 3'd2, 3'd0, 3'd1);
      2:                      return enc_i(OP_STR, 3'd2, 3'd0, 6'd0);
      3:                      return enc_m(3'd3, 9'd256);
      4, 5, 6, 7, 8, 9, 10:   return enc_r(OP_ADD, 3'd3, 3'd3, 3'd3);
      11:                     return enc_i(OP_ADDI, 3'd3, 3'd3, 6'h3F);
      12:                     return enc_i(OP_ADDI, 3'd4, 3'd3, 6'd1);
      13:                     return enc_i(OP_STR, 3'd4, 3'd0, 6'd1);
      14:                     return enc_m(3'd0, 9'd7);
      15:                     return enc_i(OP_STR, 3'd0, 3'd1, 6'd2);
      16:                     return enc_i(OP_BEQ, 3'd1, 3'd0, 6'd1);
      17:                     return enc_i(OP_STR, 3'd1, 3'd0, 6'd5);
      18:                     return enc_m(3'd6, 9'd300);
      19:                     return enc_i(OP_STR, 3'd3, 3'd6, 6'd0);
      20:                     return enc_m(3'd6, 9'd44);
      21:                     return enc_i(OP_LDR, 3'd7, 3'd6, 6'd0);
      22:                     return enc_i(OP_STR, 3'd7, 3'd0, 6'd6);
      23:                     return enc_i(OP_BEQ, 3'd1, 3'd1, 6'd1);
      24:                     return enc_i(OP_STR, 3'd1, 3'd0, 6'd7);
      25:                     return enc_r(OP_OR, 3'd5, 3'd1, 3'd4);
      26:                     return enc_i(OP_STR, 3'd5, 3'd0, 6'd8);
      27:                     return enc_b(12'hFFF);
      default:                return {OP_NOP, 12'h000};
    endcase
  endfunction

  logic                rst;
  logic [ROM_AW-1:0]   pc_q, pc_d, pc_inc;
  logic [15:0]         rf_q [8];
  logic [15:0]         mem_q [2**RAM_AW];

  logic [15:0]         instr;
  op_e                 op;
  logic [2:0]          rd_a, rs_a, rt_a;
  logic [15:0]         rd_v, rs_v, rt_v;
  logic [15:0]         imm6_sx, imm9_zx, imm12_sx;
  logic [15:0]         addr_sum, pc_ext, br6, br12;
  logic [15:0]         wb_v;
  logic                rf_we;
  logic                is_mem;
  logic [12:0]         data_adr;
  logic [15:0]         read_data, write_data;
  logic                mem_write;
  logic                unused_ok;

  assign rst = GPIO_0_PI[1];

  assign instr = TEST_ROM ? test_rom(32'(pc_q)) : main_rom(32'(pc_q));
  assign op    = op_e'(instr[15:12]);
  assign rd_a  = instr[11:9];
  assign rs_a  = instr[8:6];
  assign rt_a  = instr[5:3];

  assign imm6_sx  = {{10{instr[5]}}, instr[5:0]};
  assign imm9_zx  = {7'd0, instr[8:0]};
  assign imm12_sx = {{4{instr[11]}}, instr[11:0]};

  // R0 is hardwired to zero on every read port
  assign rd_v = (rd_a == 3'd0) ? '0 : rf_q[rd_a];
  assign rs_v = (rs_a == 3'd0) ? '0 : rf_q[rs_a];
  assign rt_v = (rt_a == 3'd0) ? '0 : rf_q[rt_a];

  assign addr_sum = rs_v + imm6_sx;
  assign pc_inc   = pc_q + ROM_AW'(1);
  // Branch targets are formed at 16 bits and truncated to the PC width
  assign pc_ext   = 16'(pc_inc);
  assign br6      = pc_ext + imm6_sx;
  assign br12     = pc_ext + imm12_sx;

  // Bus terms are kept out of the main decode block so the LDR path
  // (address -> RAM -> write-back) forms no combinational loop
  assign is_mem     = (op == OP_LDR) || (op == OP_STR);
  assign data_adr   = is_mem ? addr_sum[12:0] : '0;
  assign read_data  = mem_q[data_adr[RAM_AW-1:0]];
  assign write_data = (op == OP_STR) ? rd_v : '0;
  assign mem_write  = (op == OP_STR) && !rst;

  always_comb begin
    wb_v  = '0;
    rf_we = 1'b0;
    pc_d  = pc_inc;
    case (op)
      OP_ADD:  begin wb_v = rs_v + rt_v;    rf_we = 1'b1; end
      OP_SUB:  begin wb_v = rs_v - rt_v;    rf_we = 1'b1; end
      OP_AND:  begin wb_v = rs_v & rt_v;    rf_we = 1'b1; end
      OP_OR:   begin wb_v = rs_v | rt_v;    rf_we = 1'b1; end
      OP_ADDI: begin wb_v = rs_v + imm6_sx; rf_we = 1'b1; end
      OP_MOVI: begin wb_v = imm9_zx;        rf_we = 1'b1; end
      OP_LDR:  begin wb_v = read_data;      rf_we = 1'b1; end
      OP_BEQ:  if (rd_v == rs_v) pc_d = br6[ROM_AW-1:0];
      OP_B:    pc_d = br12[ROM_AW-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pc_q <= '0;
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && (rd_a != 3'd0)) rf_q[rd_a] <= wb_v;
    end
  end

  // RAM is never cleared; mem_write is already gated off during reset
  always_ff @(posedge CLOCK_50) begin
    if (mem_write) mem_q[data_adr[RAM_AW-1:0]] <= write_data;
  end

  assign GPIO_1 = {mem_write, 1'b0, read_data, write_data};
  assign GPIO_2 = data_adr;

  assign unused_ok = ^{GPIO_0_PI[33:2], GPIO_0_PI[0], addr_sum[15:13],
                       br6[15:ROM_AW], br12[15:ROM_AW]};

endmodule

// File: tb/tb_my_de0_nano.sv
// Bench for my_de0_nano: one instance runs the built-in program, a second
// runs the instruction-set exercise ROM. Expected bus values per executed
// instruction index come from hand-written tables.
module tb_my_de0_nano;

  logic        clk = 1'b0;
  logic [33:0] pi_m, pi_t;
  logic [33:0] g1_m, g1_t;
  logic [12:0] g2_m, g2_t;

  always #5 clk = ~clk;

  my_de0_nano #(.RAM_AW(8), .ROM_AW(6), .TEST_ROM(1'b0)) dut (
    .CLOCK_50 (clk),
    .GPIO_0_PI(pi_m),
    .GPIO_1   (g1_m),
    .GPIO_2   (g2_m)
  );

  my_de0_nano #(.RAM_AW(8), .ROM_AW(6), .TEST_ROM(1'b1)) dut_t (
    .CLOCK_50 (clk),
    .GPIO_0_PI(pi_t),
    .GPIO_1   (g1_t),
    .GPIO_2   (g2_t)
  );

  // rd_mode: 0 = ReadData not checked, 1 = must equal rd, 2 = must differ
  typedef struct {
    int          idx;
    logic        mw;
    logic [12:0] adr;
    logic [15:0] wd;
    logic [1:0]  rd_mode;
    logic [15:0] rd;
  } vec_t;

  vec_t cur_tab[$];
  vec_t test_tab[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Walks n instruction indices; indices absent from the table expect an
  // idle bus (MemWrite 0, DataAdr 0, WriteData 0).
  task automatic run_table(input bit t, input bit first_now, input int n,
                           input string tag);
    vec_t        e;
    logic [33:0] g1;
    logic [12:0] g2;
    for (int k = 0; k < n; k++) begin
      if (k > 0 || !first_now) @(negedge clk);
      else #1;
      e = '{idx: k, mw: 1'b0, adr: 13'd0, wd: 16'd0, rd_mode: 2'd0, rd: 16'd0};
      if (t) begin
        foreach (test_tab[j]) if (test_tab[j].idx == k) e = test_tab[j];
      end else begin
        foreach (cur_tab[j]) if (cur_tab[j].idx == k) e = cur_tab[j];
      end
      g1 = t ? g1_t : g1_m;
      g2 = t ? g2_t : g2_m;
      check($sformatf("%s bus k=%0d", tag, k), {2'b00, g1[33], g2, g1[15:0]},
            {2'b00, e.mw, e.adr, e.wd});
      if (e.rd_mode == 2'd1) begin
        check($sformatf("%s rdata k=%0d", tag, k), {16'd0, g1[31:16]},
              {16'd0, e.rd});
      end else if (e.rd_mode == 2'd2) begin
        checks++;
        if (g1[31:16] === e.rd) begin
          errors++;
          $display("FAIL %s rdata_old k=%0d actual=%0h required=not %0h",
                   tag, k, g1[31:16], e.rd);
        end
      end
    end
  endtask

  task automatic load_main(input bit first);
    cur_tab.delete();
    cur_tab.push_back('{22, 1'b1, 13'd220, 16'd20, first ? 2'd2 : 2'd1, 16'd20});
    cur_tab.push_back('{23, 1'b0, 13'd220, 16'd0, 2'd1, 16'd20});
  endtask

  initial begin
    pi_m = '0;
    pi_t = '0;
    pi_m[1] = 1'b1;
    pi_t[1] = 1'b1;

    test_tab.push_back('{2,  1'b1, 13'd0,   16'hFFFF, 2'd0, 16'h0000});
    test_tab.push_back('{13, 1'b1, 13'd1,   16'h8000, 2'd0, 16'h0000});
    test_tab.push_back('{15, 1'b1, 13'd3,   16'h0000, 2'd0, 16'h0000});
    test_tab.push_back('{17, 1'b1, 13'd5,   16'h0001, 2'd0, 16'h0000});
    test_tab.push_back('{19, 1'b1, 13'd300, 16'h7FFF, 2'd0, 16'h0000});
    test_tab.push_back('{21, 1'b0, 13'd44,  16'h0000, 2'd1, 16'h7FFF});
    test_tab.push_back('{22, 1'b1, 13'd6,   16'h7FFF, 2'd0, 16'h0000});
    test_tab.push_back('{25, 1'b1, 13'd8,   16'h8001, 2'd0, 16'h0000});

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset mw c%0d", i), {31'd0, g1_m[33]}, 32'd0);
      check($sformatf("reset bit32 c%0d", i), {31'd0, g1_m[32]}, 32'd0);
    end

    // First run: store at index 22 shows pre-store RAM contents
    pi_m[1] = 1'b0;
    load_main(1'b1);
    run_table(1'b0, 1'b1, 40, "run1");

    // Self-loop at PC 9 keeps the bus idle
    cur_tab.delete();
    run_table(1'b0, 1'b0, 200, "idle");

    // Restart, abort at index 10 with a one-cycle reset
    @(negedge clk);
    pi_m[1] = 1'b1;
    #1 check("rst again mw", {31'd0, g1_m[33]}, 32'd0);
    @(negedge clk);
    pi_m[1] = 1'b0;
    load_main(1'b0);
    run_table(1'b0, 1'b1, 10, "pre10");
    @(negedge clk);
    pi_m[1] = 1'b1;
    #1 check("rst mid mw", {31'd0, g1_m[33]}, 32'd0);
    @(negedge clk);
    pi_m[1] = 1'b0;

    // Rerun up to the store, then reset lands on the STR cycle
    run_table(1'b0, 1'b1, 23, "run2");
    pi_m[1] = 1'b1;
    #1;
    check("rst on str mw", {31'd0, g1_m[33]}, 32'd0);
    check("rst on str adr", {19'd0, g2_m}, 32'd220);
    @(negedge clk);
    pi_m[1] = 1'b0;
    run_table(1'b0, 1'b1, 30, "run3");

    // Instruction-set exercise ROM
    @(negedge clk);
    pi_t[1] = 1'b0;
    run_table(1'b1, 1'b1, 32, "isa");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
